sc_par_sng: RTL and testbench

SC_PAR_SNG -- requirements
Module: sc_par_sng

---
 rtl/sc_par_sng.sv | 93 +++++++++
 tb/tb_sc_par_sng.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/sc_par_sng.sv
// Parallel stochastic number generator: one LFSR, eight rotated comparators.
// Emits FRAME_LEN beats per frame over a valid/ready handshake.
module sc_par_sng #(
    parameter int INPUT_WIDTH = 8,
    parameter int FRAME_LEN   = 255
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [INPUT_WIDTH-1:0] value,
    input  logic [INPUT_WIDTH-1:0] seed,
    input  logic                   out_ready,
    output logic [INPUT_WIDTH-1:0] APC_stream_8,
    output logic                   out_valid,
    output logic                   busy,
    output logic                   done
);

    localparam int W = INPUT_WIDTH;
    localparam logic [7:0] LAST = 8'(FRAME_LEN - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state;
    logic [W-1:0]   val_r;
    logic [W-1:0]   lfsr;
    logic [7:0]     cnt;
    logic [2*W-1:0] dbl;
    logic [W-1:0]   lanes;
    logic           hs;

    assign hs = out_valid && out_ready;

    // Lane i compares the LFSR rotated left by i against the operand.
    always_comb begin
        dbl   = {lfsr, lfsr};
        lanes = '0;
        for (int i = 0; i < W; i++) begin
            lanes[i] = (dbl[2*W-1-i -: W] <= val_r);
        end
    end

    assign APC_stream_8 = out_valid ? lanes : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            lfsr      <= 8'h01;
            val_r     <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        val_r     <= value;
                        lfsr      <= (seed == '0) ? 8'h01 : seed;
                        cnt       <= '0;
                        out_valid <= 1'b1;
                        busy      <= 1'b1;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    if (hs) begin
                        lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
                        cnt  <= cnt + 8'd1;
                        if (cnt == LAST) begin
                            out_valid <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sc_par_sng.sv
// Directed self-checking bench for sc_par_sng.
// Outputs are sampled and inputs driven on the falling clock edge.
module tb_sc_par_sng;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] value;
    logic [7:0] seed;
    logic       out_ready;
    logic [7:0] APC_stream_8;
    logic       out_valid;
    logic       busy;
    logic       done;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [7:0] got  [300];
    logic [7:0] ref_a[300];
    logic [7:0] ref_b[300];

    sc_par_sng #(.INPUT_WIDTH(8), .FRAME_LEN(255)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .value        (value),
        .seed         (seed),
        .out_ready    (out_ready),
        .APC_stream_8 (APC_stream_8),
        .out_valid    (out_valid),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference beats straight from the lane/LFSR definitions.
    function automatic int model_mism(input logic [7:0] v, input logic [7:0] s);
        logic [7:0] l, b, r;
        int m;
        m = 0;
        l = (s == 8'h00) ? 8'h01 : s;
        for (int n = 0; n < 255; n++) begin
            for (int i = 0; i < 8; i++) begin
                r = (i == 0) ? l : 8'((l << i) | (l >> (8 - i)));
                b[i] = (r <= v);
            end
            if (got[n] !== b) m++;
            l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
        end
        return m;
    endfunction

    function automatic int diff_ref(input bit use_b);
        int m;
        m = 0;
        for (int n = 0; n < 255; n++)
            if (got[n] !== (use_b ? ref_b[n] : ref_a[n])) m++;
        return m;
    endfunction

    // Caller is at a falling edge; returns at a falling edge.
    task automatic run_frame(input logic [7:0] v, input logic [7:0] s,
                             input int stall_at, input int stall_len,
                             input bit hold, input bit toggle,
                             output int nb, output int lat, output int nd);
        int t0, stalled;
        logic [7:0] held;
        bit fin;
        nb = 0; nd = 0; stalled = 0; fin = 0; lat = -1; held = '0;
        value = v; seed = s; start = 1'b1; out_ready = 1'b1;
        t0 = cyc;
        for (int k = 0; k < 2000 && !fin; k++) begin
            @(negedge clk);
            if (!hold) start = 1'b0;
            if (toggle && nb == 50) begin
                value = ~v;
                seed  = s ^ 8'h5a;
            end
            if (done) begin
                nd++;
                lat = cyc - t0;
                fin = 1;
                chk("done_busy", {31'd0, busy}, 0);
                chk("done_valid", {31'd0, out_valid}, 0);
            end else if (out_valid) begin
                if (nb == stall_at && stalled < stall_len) begin
                    if (stalled == 0) held = APC_stream_8;
                    else chk("stall_hold", {24'd0, APC_stream_8}, {24'd0, held});
                    out_ready = 1'b0;
                    stalled++;
                end else begin
                    out_ready = 1'b1;
                    if (nb < 300) got[nb] = APC_stream_8;
                    nb++;
                end
            end
        end
        if (!fin) chk("frame_timeout", 0, 1);
        start = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("done_one_cycle", {31'd0, done}, 0);
    endtask

    int nb, lat, nd, bad, pop, dseen;
    int lane [8];

    initial begin
        rst_n = 1'b0; start = 1'b0; value = '0; seed = '0; out_ready = 1'b0;
        #3;
        chk("rst_valid", {31'd0, out_valid}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_stream", {24'd0, APC_stream_8}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // value 3, seed 1: first beat 03, done 256 cycles after start
        run_frame(8'h03, 8'h01, -1, 0, 0, 0, nb, lat, nd);
        chk("a_first", {24'd0, got[0]}, 32'h03);
        chk("a_beats", nb, 255);
        chk("a_latency", lat, 256);
        chk("a_done_cnt", nd, 1);
        chk("a_model", model_mism(8'h03, 8'h01), 0);
        for (int n = 0; n < 300; n++) ref_a[n] = got[n];

        // value 0x80: first beat FF, 128 ones per lane, popcount 1024
        run_frame(8'h80, 8'h01, -1, 0, 0, 0, nb, lat, nd);
        chk("b_first", {24'd0, got[0]}, 32'hff);
        chk("b_beats", nb, 255);
        pop = 0;
        for (int i = 0; i < 8; i++) lane[i] = 0;
        for (int n = 0; n < 255; n++)
            for (int i = 0; i < 8; i++)
                if (got[n][i]) begin lane[i]++; pop++; end
        for (int i = 0; i < 8; i++) chk($sformatf("b_lane%0d", i), lane[i], 128);
        chk("b_popcount", pop, 1024);
        chk("b_model", model_mism(8'h80, 8'h01), 0);
        for (int n = 0; n < 300; n++) ref_b[n] = got[n];

        // 5-cycle stall at beat 10
        run_frame(8'h80, 8'h01, 10, 5, 0, 0, nb, lat, nd);
        chk("stall_beats", nb, 255);
        chk("stall_seq", diff_ref(1), 0);
        chk("stall_latency", lat, 261);

        // extremes and seed 0
        run_frame(8'h00, 8'h5a, -1, 0, 0, 0, nb, lat, nd);
        bad = 0;
        for (int n = 0; n < 255; n++) if (got[n] !== 8'h00) bad++;
        chk("zero_beats", bad, 0);
        run_frame(8'hff, 8'h00, -1, 0, 0, 0, nb, lat, nd);
        bad = 0;
        for (int n = 0; n < 255; n++) if (got[n] !== 8'hff) bad++;
        chk("ones_beats", bad, 0);
        run_frame(8'h80, 8'h00, -1, 0, 0, 0, nb, lat, nd);
        chk("seed0_seq", diff_ref(1), 0);

        // start held high, operands toggled mid-frame
        run_frame(8'h80, 8'h01, -1, 0, 1, 1, nb, lat, nd);
        chk("hold_seq", diff_ref(1), 0);
        chk("hold_done_cnt", nd, 1);
        chk("hold_latency", lat, 256);

        // reset mid-frame at beat 100
        value = 8'h03; seed = 8'h01; start = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (100) @(negedge clk);
        chk("pre_rst_busy", {31'd0, busy}, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", {31'd0, out_valid}, 0);
        chk("mid_rst_busy", {31'd0, busy}, 0);
        chk("mid_rst_done", {31'd0, done}, 0);
        chk("mid_rst_stream", {24'd0, APC_stream_8}, 0);
        dseen = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) dseen++;
        end
        rst_n = 1'b1;
        run_frame(8'h03, 8'h01, -1, 0, 0, 0, nb, lat, nd);
        chk("rst_no_done", dseen, 0);
        chk("rst_restart_seq", diff_ref(0), 0);
        chk("rst_restart_lat", lat, 256);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
